// File: rtl/pic_inst_decoder.sv
// PIC16C5x baseline instruction decoder and Q-cycle sequencer.
// Runs the Q1..Q4 phase counter and a fetch/execute pipeline. It registers
// the ALU control word at Q1, drives ALU_En in Q3 and pulses the write and
// PC/stack strobes in Q4. A taken branch or skip flushes the next slot.

`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 5
`define ALU_IDLE  5'd0
`define ALU_ADDWF 5'd1
`define ALU_SUBWF 5'd2
`define ALU_ANDWF 5'd3
`define ALU_IORWF 5'd4
`define ALU_XORWF 5'd5
`define ALU_COMF  5'd6
`define ALU_DECF  5'd7
`define ALU_INCF  5'd8
`define ALU_RLF   5'd9
`define ALU_RRF   5'd10
`define ALU_SWAPF 5'd11
`define ALU_MOVF  5'd12
`define ALU_ANDLW 5'd13
`define ALU_IORLW 5'd14
`define ALU_XORLW 5'd15
`define ALU_BCF   5'd16
`define ALU_BSF   5'd17
`endif

module pic_inst_decoder #(
    parameter int INST_WIDTH   = 12,
    parameter int F_ADDR_WIDTH = 5,
    parameter int PC_WIDTH     = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_WIDTH-1:0]      instIn,
    input  logic [7:0]                 aluResultIn,
    output logic [1:0]                 qPhase,
    output logic [`ALU_FUNC_WIDTH-1:0] aluFunc,
    output logic [2:0]                 bitSel,
    output logic [7:0]                 aluLit,
    output logic                       ALU_En,
    output logic [F_ADDR_WIDTH-1:0]    fAddr,
    output logic                       fWrEn,
    output logic                       wWrEn,
    output logic                       wSrcLit,
    output logic                       pcInc,
    output logic                       pcLoad,
    output logic [PC_WIDTH-1:0]        pcTarget,
    output logic                       stackPush,
    output logic                       stackPop
);

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_e;

    // Fully decoded instruction word; it stands in for the instruction register.
    typedef struct packed {
        logic [`ALU_FUNC_WIDTH-1:0] alu_func;
        logic [2:0]                 bit_sel;
        logic [7:0]                 lit;
        logic [F_ADDR_WIDTH-1:0]    f_addr;
        logic                       w_src_lit;
        logic [PC_WIDTH-1:0]        pc_target;
        logic                       status_en;
        logic                       f_wr;
        logic                       w_wr;
        logic                       pc_load;
        logic                       push;
        logic                       pop;
        logic                       skip_zero;
        logic                       skip_clr;
        logic                       skip_set;
    } ctrl_t;

    phase_e phase_q, phase_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   flush_q, flush_d;
    logic   alu_en_q, alu_en_d;
    logic   f_wr_q, f_wr_d;
    logic   w_wr_q, w_wr_d;
    logic   pc_inc_q, pc_inc_d;
    logic   pc_load_q, pc_load_d;
    logic   push_q, push_d;
    logic   pop_q, pop_d;
    logic   skip_taken;

    // Baseline 12-bit opcode map to control word
    function automatic ctrl_t decode(input logic [INST_WIDTH-1:0] i);
        ctrl_t c;
        logic  file_op;
        c          = '0;
        file_op    = 1'b0;
        c.alu_func = `ALU_IDLE;
        c.f_addr   = F_ADDR_WIDTH'(i[4:0]);
        casez (i[11:6])
            6'b000000: begin
                if (i[5]) begin
                    c.alu_func = `ALU_IORLW;
                    c.f_wr     = 1'b1;
                end
            end
            6'b000001: begin c.alu_func = `ALU_ANDLW; c.status_en = 1'b1; file_op = 1'b1; end
            6'b000010: begin c.alu_func = `ALU_SUBWF; c.status_en = 1'b1; file_op = 1'b1; end
            6'b000011: begin c.alu_func = `ALU_DECF;  c.status_en = 1'b1; file_op = 1'b1; end
            6'b000100: begin c.alu_func = `ALU_IORWF; c.status_en = 1'b1; file_op = 1'b1; end
            6'b000101: begin c.alu_func = `ALU_ANDWF; c.status_en = 1'b1; file_op = 1'b1; end
            6'b000110: begin c.alu_func = `ALU_XORWF; c.status_en = 1'b1; file_op = 1'b1; end
            6'b000111: begin c.alu_func = `ALU_ADDWF; c.status_en = 1'b1; file_op = 1'b1; end
            6'b001000: begin c.alu_func = `ALU_MOVF;  c.status_en = 1'b1; file_op = 1'b1; end
            6'b001001: begin c.alu_func = `ALU_COMF;  c.status_en = 1'b1; file_op = 1'b1; end
            6'b001010: begin c.alu_func = `ALU_INCF;  c.status_en = 1'b1; file_op = 1'b1; end
            6'b001011: begin c.alu_func = `ALU_DECF;  c.skip_zero = 1'b1; file_op = 1'b1; end
            6'b001100: begin c.alu_func = `ALU_RRF;   c.status_en = 1'b1; file_op = 1'b1; end
            6'b001101: begin c.alu_func = `ALU_RLF;   c.status_en = 1'b1; file_op = 1'b1; end
            6'b001110: begin c.alu_func = `ALU_SWAPF; file_op = 1'b1; end
            6'b001111: begin c.alu_func = `ALU_INCF;  c.skip_zero = 1'b1; file_op = 1'b1; end
            6'b0100??: begin c.alu_func = `ALU_BCF; c.bit_sel = i[7:5]; c.f_wr = 1'b1; end
            6'b0101??: begin c.alu_func = `ALU_BSF; c.bit_sel = i[7:5]; c.f_wr = 1'b1; end
            6'b0110??: begin c.alu_func = `ALU_MOVF; c.bit_sel = i[7:5]; c.skip_clr = 1'b1; end
            6'b0111??: begin c.alu_func = `ALU_MOVF; c.bit_sel = i[7:5]; c.skip_set = 1'b1; end
            6'b1000??: begin
                c.lit       = i[7:0];
                c.pop       = 1'b1;
                c.pc_load   = 1'b1;
                c.w_wr      = 1'b1;
                c.w_src_lit = 1'b1;
            end
            6'b1001??: begin
                c.pc_load   = 1'b1;
                c.push      = 1'b1;
                c.pc_target = PC_WIDTH'({1'b0, i[7:0]});
            end
            6'b101???: begin
                c.pc_load   = 1'b1;
                c.pc_target = PC_WIDTH'(i[8:0]);
            end
            6'b1100??: begin c.lit = i[7:0]; c.w_wr = 1'b1; c.w_src_lit = 1'b1; end
            6'b1101??: begin c.alu_func = `ALU_IORLW; c.lit = i[7:0]; c.status_en = 1'b1; c.w_wr = 1'b1; end
            6'b1110??: begin c.alu_func = `ALU_ANDLW; c.lit = i[7:0]; c.status_en = 1'b1; c.w_wr = 1'b1; end
            6'b1111??: begin c.alu_func = `ALU_XORLW; c.lit = i[7:0]; c.status_en = 1'b1; c.w_wr = 1'b1; end
            default: ;
        endcase
        if (file_op) begin
            c.f_wr = i[5];
            c.w_wr = ~i[5];
        end
        return c;
    endfunction

    // Skip condition of the executing instruction, valid during Q4
    always_comb begin
        skip_taken = (ctrl_q.skip_zero && (aluResultIn == 8'h00)) ||
                     (ctrl_q.skip_clr  && !aluResultIn[ctrl_q.bit_sel]) ||
                     (ctrl_q.skip_set  &&  aluResultIn[ctrl_q.bit_sel]);
    end

    // Phase sequencing, fetch into the decoded word, strobe generation
    always_comb begin
        phase_d   = phase_e'(phase_q + 2'd1);
        ctrl_d    = ctrl_q;
        flush_d   = flush_q;
        alu_en_d  = 1'b0;
        f_wr_d    = 1'b0;
        w_wr_d    = 1'b0;
        pc_inc_d  = 1'b0;
        pc_load_d = 1'b0;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        unique case (phase_q)
            Q2: alu_en_d = ctrl_q.status_en;
            Q3: begin
                f_wr_d    = ctrl_q.f_wr;
                w_wr_d    = ctrl_q.w_wr;
                pc_inc_d  = ~ctrl_q.pc_load;
                pc_load_d = ctrl_q.pc_load;
                push_d    = ctrl_q.push;
                pop_d     = ctrl_q.pop;
                flush_d   = flush_q | ctrl_q.pc_load;
            end
            Q4: begin
                ctrl_d  = decode((flush_q || skip_taken) ? '0 : instIn);
                flush_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State registers with asynchronous reset to a flushed NOP slot at Q1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q         <= Q1;
            ctrl_q          <= '0;
            ctrl_q.alu_func <= `ALU_IDLE;
            flush_q         <= 1'b1;
            alu_en_q        <= 1'b0;
            f_wr_q          <= 1'b0;
            w_wr_q          <= 1'b0;
            pc_inc_q        <= 1'b0;
            pc_load_q       <= 1'b0;
            push_q          <= 1'b0;
            pop_q           <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            ctrl_q    <= ctrl_d;
            flush_q   <= flush_d;
            alu_en_q  <= alu_en_d;
            f_wr_q    <= f_wr_d;
            w_wr_q    <= w_wr_d;
            pc_inc_q  <= pc_inc_d;
            pc_load_q <= pc_load_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
        end
    end

    assign qPhase    = phase_q;
    assign aluFunc   = ctrl_q.alu_func;
    assign bitSel    = ctrl_q.bit_sel;
    assign aluLit    = ctrl_q.lit;
    assign fAddr     = ctrl_q.f_addr;
    assign wSrcLit   = ctrl_q.w_src_lit;
    assign pcTarget  = ctrl_q.pc_target;
    assign ALU_En    = alu_en_q;
    assign fWrEn     = f_wr_q;
    assign wWrEn     = w_wr_q;
    assign pcInc     = pc_inc_q;
    assign pcLoad    = pc_load_q;
    assign stackPush = push_q;
    assign stackPop  = pop_q;

endmodule

// File: tb/tb_pic_inst_decoder.sv
// Bench for pic_inst_decoder: directed test-plan steps followed by random
// instructions, checked against an instruction-cycle level reference model.

`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 5
`define ALU_IDLE  5'd0
`define ALU_ADDWF 5'd1
`define ALU_SUBWF 5'd2
`define ALU_ANDWF 5'd3
`define ALU_IORWF 5'd4
`define ALU_XORWF 5'd5
`define ALU_COMF  5'd6
`define ALU_DECF  5'd7
`define ALU_INCF  5'd8
`define ALU_RLF   5'd9
`define ALU_RRF   5'd10
`define ALU_SWAPF 5'd11
`define ALU_MOVF  5'd12
`define ALU_ANDLW 5'd13
`define ALU_IORLW 5'd14
`define ALU_XORLW 5'd15
`define ALU_BCF   5'd16
`define ALU_BSF   5'd17
`endif

module tb_pic_inst_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] instIn;
    logic [7:0]  aluResultIn;
    logic [1:0]  qPhase;
    logic [4:0]  aluFunc;
    logic [2:0]  bitSel;
    logic [7:0]  aluLit;
    logic        ALU_En;
    logic [4:0]  fAddr;
    logic        fWrEn, wWrEn, wSrcLit, pcInc, pcLoad, stackPush, stackPop;
    logic [8:0]  pcTarget;

    int checks   = 0;
    int failures = 0;

    pic_inst_decoder dut (
        .clk(clk), .rst(rst), .instIn(instIn), .aluResultIn(aluResultIn),
        .qPhase(qPhase), .aluFunc(aluFunc), .bitSel(bitSel), .aluLit(aluLit),
        .ALU_En(ALU_En), .fAddr(fAddr), .fWrEn(fWrEn), .wWrEn(wWrEn),
        .wSrcLit(wSrcLit), .pcInc(pcInc), .pcLoad(pcLoad), .pcTarget(pcTarget),
        .stackPush(stackPush), .stackPop(stackPop)
    );

    always #5 clk = ~clk;

    logic [39:0] obs;
    assign obs = {qPhase, aluFunc, bitSel, aluLit, ALU_En, fAddr, fWrEn, wWrEn,
                  wSrcLit, pcInc, pcLoad, pcTarget, stackPush, stackPop};

    typedef struct packed {
        logic [4:0] func;
        logic [2:0] bsel;
        logic [7:0] lit;
        logic       en;
        logic [4:0] f;
        logic       fwr, wwr, wsl, load, push, pop, skz, bc, bs;
        logic [8:0] tgt;
    } exp_t;

    // Byte-oriented file operations indexed by opcode bits [9:6]
    localparam logic [4:0] FILE_FUNC [16] = '{
        `ALU_IDLE, `ALU_ANDLW, `ALU_SUBWF, `ALU_DECF, `ALU_IORWF, `ALU_ANDWF,
        `ALU_XORWF, `ALU_ADDWF, `ALU_MOVF, `ALU_COMF, `ALU_INCF, `ALU_DECF,
        `ALU_RRF, `ALU_RLF, `ALU_SWAPF, `ALU_INCF};
    localparam logic [15:0] FILE_EN = 16'h37FE;

    logic [11:0] cur;
    logic        m_flush;

    function automatic exp_t m_decode(input logic [11:0] i);
        exp_t e;
        int   op;
        e = '0;
        e.f = i[4:0];
        if (i[11:10] == 2'b00) begin
            op = int'(i[9:6]);
            if (op == 0) begin
                if (i[5]) begin e.func = `ALU_IORLW; e.fwr = 1'b1; end
            end else begin
                e.func = FILE_FUNC[op];
                e.en   = FILE_EN[op];
                e.fwr  = i[5];
                e.wwr  = !i[5];
                e.skz  = (op == 11) || (op == 15);
            end
        end else if (i[11:10] == 2'b01) begin
            e.bsel = i[7:5];
            case (i[9:8])
                2'd0: begin e.func = `ALU_BCF; e.fwr = 1'b1; end
                2'd1: begin e.func = `ALU_BSF; e.fwr = 1'b1; end
                2'd2: begin e.func = `ALU_MOVF; e.bc = 1'b1; end
                default: begin e.func = `ALU_MOVF; e.bs = 1'b1; end
            endcase
        end else begin
            case (i[11:8])
                4'h8: begin e.lit = i[7:0]; e.pop = 1'b1; e.load = 1'b1; e.wwr = 1'b1; e.wsl = 1'b1; end
                4'h9: begin e.load = 1'b1; e.push = 1'b1; e.tgt = {1'b0, i[7:0]}; end
                4'hA, 4'hB: begin e.load = 1'b1; e.tgt = i[8:0]; end
                4'hC: begin e.lit = i[7:0]; e.wwr = 1'b1; e.wsl = 1'b1; end
                4'hD: begin e.func = `ALU_IORLW; e.lit = i[7:0]; e.en = 1'b1; e.wwr = 1'b1; end
                4'hE: begin e.func = `ALU_ANDLW; e.lit = i[7:0]; e.en = 1'b1; e.wwr = 1'b1; end
                default: begin e.func = `ALU_XORLW; e.lit = i[7:0]; e.en = 1'b1; e.wwr = 1'b1; end
            endcase
        end
        return e;
    endfunction

    function automatic logic [39:0] exp_vec(input exp_t e, input logic [1:0] p);
        logic q3, q4;
        q3 = (p == 2'd2);
        q4 = (p == 2'd3);
        return {p, e.func, e.bsel, e.lit, q3 && e.en, e.f, q4 && e.fwr, q4 && e.wwr,
                e.wsl, q4 && !e.load, q4 && e.load, e.tgt, q4 && e.push, q4 && e.pop};
    endfunction

    task automatic check_vec(input string tag, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One instruction cycle: execute cur, fetch nxt, present alu during the cycle
    task automatic step(input logic [11:0] nxt, input logic [7:0] alu);
        exp_t e;
        logic sk;
        e = m_decode(cur);
        instIn = nxt;
        aluResultIn = alu;
        check_vec($sformatf("Q1 inst=%h", cur), exp_vec(e, 2'd0));
        for (int p = 1; p < 4; p++) begin
            @(posedge clk); #1;
            check_vec($sformatf("Q%0d inst=%h alu=%h", p + 1, cur, alu), exp_vec(e, p[1:0]));
        end
        sk = (e.skz && alu == 8'h00) || (e.bc && !alu[e.bsel]) || (e.bs && alu[e.bsel]);
        @(posedge clk); #1;
        cur = (m_flush || e.load || sk) ? 12'h000 : nxt;
        m_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        instIn = 12'h000;
        aluResultIn = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        check_vec("reset_state", 40'h0);
        @(negedge clk);
        rst = 1'b0;
        cur = 12'h000;
        m_flush = 1'b1;

        // Bring an ADDWF into execution, then reset it mid-Q3
        step(12'h1E3, 8'h00);
        step(12'h1E3, 8'h00);
        e = m_decode(cur);
        check_vec("pre_reset_Q1", exp_vec(e, 2'd0));
        @(posedge clk); #1;
        check_vec("pre_reset_Q2", exp_vec(e, 2'd1));
        @(posedge clk); #1;
        check_vec("pre_reset_Q3", exp_vec(e, 2'd2));
        #2 rst = 1'b1;
        #1 check_vec("reset_async", 40'h0);
        @(posedge clk); #1;
        check_vec("reset_hold", 40'h0);
        @(negedge clk);
        rst = 1'b0;
        cur = 12'h000;
        m_flush = 1'b1;

        // Directed steps from the test plan
        step(12'h1E3, 8'h00);  // first cycle after reset: flushed
        step(12'h1E3, 8'h00);  // NOP, fetch ADDWF
        step(12'h000, 8'h55);  // ADDWF executes
        step(12'h2D0, 8'h00);
        step(12'h123, 8'h00);  // DECFSZ, result zero -> skip
        step(12'h2D0, 8'h00);  // flushed slot
        step(12'h123, 8'h01);  // DECFSZ, result one -> no skip
        step(12'h6E7, 8'h00);  // IORWF executes
        step(12'h123, 8'h7F);  // BTFSC bit7 clear -> skip
        step(12'h6E7, 8'h00);
        step(12'h123, 8'h80);  // BTFSC bit7 set -> no skip
        step(12'h7E7, 8'h00);
        step(12'h123, 8'h7F);  // BTFSS bit7 clear -> no skip
        step(12'h7E7, 8'h00);
        step(12'h123, 8'h80);  // BTFSS bit7 set -> skip
        step(12'hA55, 8'h00);
        step(12'h912, 8'h00);  // GOTO, CALL fetch flushed
        step(12'h912, 8'h00);
        step(12'h8AB, 8'h00);  // CALL
        step(12'h8AB, 8'h00);
        step(12'h040, 8'h00);  // RETLW
        step(12'h040, 8'h00);
        step(12'hC3C, 8'h00);  // CLRW
        step(12'h000, 8'h00);  // MOVLW

        // Random instruction stream with frequent zero ALU results
        for (int n = 0; n < 400; n++) begin
            logic [11:0] ri;
            logic [7:0]  ra;
            ri = 12'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(ri, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
